// File: rtl/sram_responder.sv
// Word-array responder behind a valid/ready request/response handshake.
// Optional SRAM_RAND_DELAY_EN adds 0..7 LFSR-driven wait cycles per request.
module sram_responder #(
   parameter logic [31:0] ADDR_BASE   = 32'h80000000,
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter int unsigned LATENCY     = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wmask,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        wen_q, wen_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wmask_q, wmask_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        wr_en;
   logic [4:0]  cnt_load;

   logic [31:0] mem_q [DEPTH_WORDS];

   logic [31:0]   off;
   logic          acc_err;
   logic [IW-1:0] idx;

`ifdef SRAM_RAND_DELAY_EN
   logic [7:0] lfsr_q;
   logic       lfsr_fb;

   // x^8+x^6+x^5+x^4+1, Fibonacci form
   assign lfsr_fb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
   assign cnt_load = 5'(LATENCY) + {2'b00, lfsr_q[2:0]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) lfsr_q <= 8'hA5;
      else      lfsr_q <= {lfsr_q[6:0], lfsr_fb};
   end
`else
   assign cnt_load = 5'(LATENCY);
`endif

   assign off     = addr_q - ADDR_BASE;
   assign acc_err = (addr_q[1:0] != 2'b00) | ({1'b0, off} >= SPAN);
   assign idx     = off[IW+1:2];

   assign req_ready  = (state_q == S_IDLE);
   assign resp_valid = (state_q == S_RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wen_d   = wen_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wmask_d = wmask_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      wr_en   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               wen_d   = req_wen;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               wmask_d = req_wmask;
               cnt_d   = cnt_load;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (cnt_q == 5'd0) begin
               state_d = S_RESP;
               err_d   = acc_err;
               rdata_d = (!wen_q && !acc_err) ? mem_q[idx] : 32'h0;
               wr_en   = wen_q & ~acc_err;
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
         S_RESP: begin
            if (resp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 5'd0;
         wen_q   <= 1'b0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         wmask_q <= 4'h0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wen_q   <= wen_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Array contents survive reset; commits only happen from BUSY.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wmask_q[b]) mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder with a reference model and scoreboard.
// Builds with or without SRAM_RAND_DELAY_EN.
module tb_sram_responder;

   localparam int unsigned LAT = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_wen = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic [3:0]  req_wmask = 4'h0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_err;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [31:0] rd;
      logic        er;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mdl [int unsigned];

   always #5 clk = ~clk;

   sram_responder #(
      .ADDR_BASE  (32'h80000000),
      .DEPTH_WORDS(4096),
      .LATENCY    (LAT)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wen   (req_wen),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wmask (req_wmask),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_rdata(resp_rdata),
      .resp_err  (resp_err)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void model(input logic wen, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [3:0] m,
                                 output logic [31:0] rd, output logic er);
      logic [31:0] off;
      logic [31:0] w;
      int unsigned ix;
      off = a - 32'h80000000;
      er  = (a[1:0] != 2'b00) || (off >= 32'h0000_4000);
      rd  = 32'h0;
      if (!er) begin
         ix = off >> 2;
         w  = mdl.exists(ix) ? mdl[ix] : 32'hxxxxxxxx;
         if (wen) begin
            for (int i = 0; i < 4; i++)
               if (m[i]) w[8*i +: 8] = wd[8*i +: 8];
            mdl[ix] = w;
         end else begin
            rd = w;
         end
      end
   endfunction

   task automatic do_req(input logic wen, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] m,
                         input int hold, input string tag);
      exp_t e;
      int   n;
      model(wen, a, wd, m, e.rd, e.er);
      sb.push_back(e);
      req_valid = 1'b1;
      req_wen   = wen;
      req_addr  = a;
      req_wdata = wd;
      req_wmask = m;
      check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = (hold > 0);
      n = 0;
      while (!resp_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
`ifdef SRAM_RAND_DELAY_EN
      check({tag, "_lat_range"}, 32'(n >= LAT + 1 && n <= LAT + 8), 32'd1);
`else
      check({tag, "_latency"}, 32'(n), 32'(LAT + 1));
`endif
      e = sb.pop_front();
      check({tag, "_rdata"}, resp_rdata, e.rd);
      check({tag, "_err"}, 32'(resp_err), 32'(e.er));
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         check({tag, "_bp_valid"}, 32'(resp_valid), 32'd1);
         check({tag, "_bp_rdata"}, resp_rdata, e.rd);
         check({tag, "_bp_ready"}, 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      req_valid  = 1'b0;
      check({tag, "_done_valid"}, 32'(resp_valid), 32'd0);
      check({tag, "_done_ready"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_resp_err", 32'(resp_err), 32'd0);
      @(posedge clk); #1;

      do_req(1'b1, 32'h80000010, 32'hDEADBEEF, 4'hF, 0, "wr_full");
      do_req(1'b0, 32'h80000010, 32'h0, 4'h0, 0, "rd_full");
      do_req(1'b1, 32'h80000010, 32'h11223344, 4'b0101, 0, "wr_mask");
      do_req(1'b0, 32'h80000010, 32'h0, 4'h0, 0, "rd_mask");
      do_req(1'b1, 32'h80000010, 32'hFFFFFFFF, 4'b0000, 0, "wr_nomask");
      do_req(1'b0, 32'h80000010, 32'h0, 4'h0, 0, "rd_nomask");

      do_req(1'b0, 32'h80000002, 32'h0, 4'h0, 0, "err_misal");
      do_req(1'b0, 32'h7FFFFFFC, 32'h0, 4'h0, 0, "err_below");
      do_req(1'b0, 32'h80004000, 32'h0, 4'h0, 0, "err_above");
      do_req(1'b1, 32'h80000000, 32'hA5A55A5A, 4'hF, 0, "wr_word0");
      do_req(1'b1, 32'h80004000, 32'h01020304, 4'hF, 0, "wr_oob");
      do_req(1'b0, 32'h80000000, 32'h0, 4'h0, 0, "rd_word0");
      do_req(1'b0, 32'h80003FFC, 32'h0, 4'h0, 0, "rd_last_x");
      do_req(1'b1, 32'h80003FFC, 32'h0BADF00D, 4'hF, 0, "wr_last");
      do_req(1'b0, 32'h80003FFC, 32'h0, 4'h0, 0, "rd_last");

      do_req(1'b0, 32'h80000010, 32'h0, 4'h0, 5, "backpr");

      do_req(1'b1, 32'h80000020, 32'hCAFEF00D, 4'hF, 0, "wr_pre");
      req_valid = 1'b1;
      req_wen   = 1'b1;
      req_addr  = 32'h80000020;
      req_wdata = 32'h12345678;
      req_wmask = 4'hF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("mid_busy_ready", 32'(req_ready), 32'd0);
      rst = 1'b0;
      #1;
      check("mid_rst_valid", 32'(resp_valid), 32'd0);
      check("mid_rst_ready", 32'(req_ready), 32'd1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         check("mid_no_resp", 32'(resp_valid), 32'd0);
      end
      do_req(1'b0, 32'h80000020, 32'h0, 4'h0, 0, "rd_after_rst");

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
